// File: rtl/down_timer_pkg.sv
// Shared types for the loadable down-counting timer.
package down_timer_pkg;

    // Controller state: waiting for a load, counting, or one-shot expired.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : down_timer_pkg

// File: rtl/down_timer.sv
// Loadable, ce-gated down-counting timer with one-shot and periodic modes.
// A period loaded as N expires after N+1 ce ticks, raising tc for one cycle.
module down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_val,
    input  logic             load_periodic,
    input  logic             stop,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             mode_q,   mode_d;
    logic             tc_q,     tc_d;
    logic             load_acc;

    // A load is taken whenever the timer is not running; it overrides stop.
    assign load_acc = load_valid && (state_q != ST_RUN);

    // Next-state and datapath: load, decrement, expiry reload/stop, abort.
    always_comb begin
        // NOTE: every _d gets a hold default first so no path through the case infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        mode_d   = mode_q;
        tc_d     = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load_acc) begin
                    // ce in the accept cycle is deliberately ignored.
                    cnt_d    = load_val;
                    period_d = load_val;
                    mode_d   = load_periodic;
                    state_d  = ST_RUN;
                end else if (stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    // Abort beats ce; period and mode survive for inspection.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (ce) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - WIDTH'(1);
                    end else begin
                        // Zero is the expiry tick, so the decrement never underflows.
                        tc_d = 1'b1;
                        if (mode_q) begin
                            cnt_d = period_q;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers, cleared immediately by the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            mode_q   <= 1'b0;
            tc_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            tc_q     <= tc_d;
        end
    end

    // Output decode: all outputs come straight from registers.
    always_comb begin
        cnt        = cnt_q;
        tc         = tc_q;
        busy       = (state_q == ST_RUN);
        done       = (state_q == ST_DONE);
        load_ready = (state_q != ST_RUN);
    end

endmodule : down_timer
